memory_bus_ctrl: RTL and testbench
==================================

Name: memory_bus_ctrl

Overview:
Parametrised successor to the 6502 system memory/I-O decoder. Decodes CPU bus requests into general RAM, video RAM, external ROM and a UART register block, and returns read data with an explicit ready handshake. Adds TX/RX byte FIFOs between the CPU and the byte-level UART core, a status register with sticky overflow flags, and a registered dual-port VGA read path. Sits between the CPU core and the ROM, UART core and VGA text controller.

Parameters:
RAM_AW, 11, general RAM address width; RAM occupies 0 .. 2^RAM_AW-1
VRAM_BASE, 16'hE000, video RAM base address
VRAM_AW, 10, video RAM address width (depth 2^VRAM_AW)
ROM_BASE, 16'hC000, ROM region start; ROM runs to 16'hFFFF
IO_BASE, 16'hD010, base of the 4-byte UART register block (must be 4-aligned)
TXQ_AW, 4, TX FIFO address width (depth 2^TXQ_AW)
RXQ_AW, 4, RX FIFO address width (depth 2^RXQ_AW)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  16  CPU byte address
wdata  in  8  CPU write data
rdata  out  8  read data; valid when mem_ready=1
mem_read_req  in  1  one-cycle read request
mem_write_req  in  1  one-cycle write request
mem_ready  out  1  one-cycle completion pulse for every request
rom_addr  out  16  ROM address (combinational copy of address)
rom_data  in  8  ROM data, combinational
uart_tx_data  out  8  byte to UART core
uart_tx_start  out  1  one-cycle start pulse to UART core
uart_tx_busy  in  1  UART core transmitting
uart_rx_data  in  8  received byte
uart_rx_ready  in  1  one-cycle pulse, uart_rx_data valid
vga_addr  in  VRAM_AW  VGA read address
vga_data  out  8  VRAM byte at vga_addr, one-cycle latency
irq_rx  out  1  high while RX FIFO non-empty

Behaviour:
- Reset: rdata=0, mem_ready=0, uart_tx_start=0, uart_tx_data=0, vga_data=0, irq_rx=0; both FIFOs empty; sticky flags clear; TX FSM in TX_IDLE. RAM/VRAM contents not reset.
- Request: sampled on the clock edge where the req is high; mem_ready pulses exactly 1 cycle later with rdata (reads) or write committed. Read wins if both reqs high (write ignored). Back-to-back requests on consecutive cycles are each accepted.
- Decode priority: RAM (address < 2^RAM_AW) > IO block (IO_BASE..IO_BASE+3) > VRAM (VRAM_BASE..+2^VRAM_AW-1) > ROM (>= ROM_BASE) > unmapped. Unmapped reads return 8'hFF; unmapped and ROM writes are ignored but still acknowledged.
- IO registers (offset from IO_BASE):
  +0 RXDATA read: head of RX FIFO and pop; if empty returns 8'h00, no pop. Write ignored.
  +1 STATUS read: bit0 rx_nonempty, bit1 tx_full, bit2 rx_overflow (sticky), bit3 tx_overflow (sticky), bit4 tx_idle (TX FIFO empty and FSM in TX_IDLE and !uart_tx_busy), bits7:5 = 0.
  +2 TXDATA write: push wdata; if full, byte dropped and tx_overflow set. Read returns 8'h00.
  +3 CTRL write: bit0=1 clears both sticky flags; bit1=1 flushes both FIFOs. Read returns 8'h00.
- RX capture: uart_rx_ready pushes uart_rx_data. If full, byte dropped, rx_overflow set. Simultaneous pop and push on a full FIFO: both occur, no overflow. Sticky set and CTRL clear in same cycle: set wins.
- TX FSM: TX_IDLE -> TX_START when FIFO non-empty and !uart_tx_busy (pop head into uart_tx_data, pulse uart_tx_start 1 cycle). TX_START -> TX_WAIT next cycle. TX_WAIT -> TX_IDLE when uart_tx_busy observed high then low, or if busy never rises within 4 cycles. Simultaneous CPU push and FSM pop on a full FIFO: both occur, no overflow.
- FIFO counters use one extra bit; pointers wrap modulo depth. Flush during TX_WAIT does not abort the byte in flight.
- VGA: vga_data <= vram[vga_addr] every cycle, independent of CPU traffic; a same-cycle CPU write to the same address returns old data.
- irq_rx combinational from RX count != 0.

Test Plan:
- Write 8'hA5 to 16'h0123, read back -> mem_ready 1 cycle after each req, rdata=8'hA5; read 16'h9000 -> 8'hFF.
- Write 8'h41 to 16'hE005, drive vga_addr=5 -> vga_data=8'h41 next cycle; read 16'hE005 -> 8'h41 (not ROM data).
- Push 3 bytes 8'h10,11,12 to TXDATA with uart_tx_busy model of 10 cycles -> three uart_tx_start pulses in order 10,11,12; STATUS bit4 returns to 1 afterwards.
- Push 17 bytes with uart_tx_busy held high -> 16 queued, STATUS=8'h0A (tx_full, tx_overflow); CTRL write 8'h01 -> bit3 clears.
- Inject 17 rx_ready pulses (bytes 0..16) with no reads -> STATUS bit2 set; 16 RXDATA reads return 0..15, 17th returns 8'h00, irq_rx falls after 16th.
- Assert reset_n low mid TX_WAIT with bytes queued -> all outputs to reset values, FIFOs empty, no further uart_tx_start after release.

Source files
------------

// File: rtl/memory_bus_ctrl.sv
// CPU memory/IO decoder: RAM, VRAM, ROM and a FIFO-buffered UART register block,
// with a one-cycle ready handshake and a registered VGA read port into VRAM.
module memory_bus_ctrl #(
    parameter int unsigned RAM_AW    = 11,
    parameter logic [15:0] VRAM_BASE = 16'hE000,
    parameter int unsigned VRAM_AW   = 10,
    parameter logic [15:0] ROM_BASE  = 16'hC000,
    parameter logic [15:0] IO_BASE   = 16'hD010,
    parameter int unsigned TXQ_AW    = 4,
    parameter int unsigned RXQ_AW    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        address,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    input  logic               mem_read_req,
    input  logic               mem_write_req,
    output logic               mem_ready,
    output logic [15:0]        rom_addr,
    input  logic [7:0]         rom_data,
    output logic [7:0]         uart_tx_data,
    output logic               uart_tx_start,
    input  logic               uart_tx_busy,
    input  logic [7:0]         uart_rx_data,
    input  logic               uart_rx_ready,
    input  logic [VRAM_AW-1:0] vga_addr,
    output logic [7:0]         vga_data,
    output logic               irq_rx
);

    localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
    localparam int unsigned VRAM_DEPTH = 1 << VRAM_AW;
    localparam int unsigned TXQ_DEPTH  = 1 << TXQ_AW;
    localparam int unsigned RXQ_DEPTH  = 1 << RXQ_AW;
    localparam int unsigned TXC_W      = TXQ_AW + 1;
    localparam int unsigned RXC_W      = RXQ_AW + 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_t;

    logic [7:0] ram    [RAM_DEPTH];
    logic [7:0] vram   [VRAM_DEPTH];
    logic [7:0] tx_mem [TXQ_DEPTH];
    logic [7:0] rx_mem [RXQ_DEPTH];

    logic [TXQ_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TXC_W-1:0]  tx_count;
    logic [RXQ_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RXC_W-1:0]  rx_count;
    logic              rx_ovf, tx_ovf;

    tx_state_t tx_state, tx_next;
    logic      tx_pop_c;
    logic      busy_seen;
    logic [1:0] wait_cnt;

    // Address decode with priority RAM > IO > VRAM > ROM
    logic in_ram_c, in_io_c, in_vram_c, in_rom_c;
    logic sel_ram_c, sel_io_c, sel_vram_c, sel_rom_c;
    assign in_ram_c   = 32'(address) < RAM_DEPTH;
    assign in_io_c    = address[15:2] == IO_BASE[15:2];
    assign in_vram_c  = (32'(address) >= 32'(VRAM_BASE)) &&
                        (32'(address) < (32'(VRAM_BASE) + VRAM_DEPTH));
    assign in_rom_c   = address >= ROM_BASE;
    assign sel_ram_c  = in_ram_c;
    assign sel_io_c   = !in_ram_c && in_io_c;
    assign sel_vram_c = !in_ram_c && !in_io_c && in_vram_c;
    assign sel_rom_c  = !in_ram_c && !in_io_c && !in_vram_c && in_rom_c;

    logic [RAM_AW-1:0]  ram_idx_c;
    logic [VRAM_AW-1:0] vram_idx_c;
    assign ram_idx_c  = address[RAM_AW-1:0];
    assign vram_idx_c = VRAM_AW'(address - VRAM_BASE);

    // Request qualification; read wins over a simultaneous write
    logic rd_c, wr_c;
    logic io_rd_rx_c, io_wr_tx_c, io_wr_ctrl_c, clr_sticky_c, flush_c;
    assign rd_c         = mem_read_req;
    assign wr_c         = mem_write_req && !mem_read_req;
    assign io_rd_rx_c   = rd_c && sel_io_c && (address[1:0] == 2'd0);
    assign io_wr_tx_c   = wr_c && sel_io_c && (address[1:0] == 2'd2);
    assign io_wr_ctrl_c = wr_c && sel_io_c && (address[1:0] == 2'd3);
    assign clr_sticky_c = io_wr_ctrl_c && wdata[0];
    assign flush_c      = io_wr_ctrl_c && wdata[1];

    // FIFO handshakes: a full FIFO still accepts a push when it pops the same cycle
    logic rx_full_c, rx_pop_c, rx_push_ok_c, rx_ovf_set_c;
    logic tx_full_c, tx_push_ok_c, tx_ovf_set_c;
    assign rx_full_c    = rx_count == RXC_W'(RXQ_DEPTH);
    assign rx_pop_c     = io_rd_rx_c && (rx_count != '0);
    assign rx_push_ok_c = uart_rx_ready && (!rx_full_c || rx_pop_c);
    assign rx_ovf_set_c = uart_rx_ready && rx_full_c && !rx_pop_c;
    assign tx_full_c    = tx_count == TXC_W'(TXQ_DEPTH);
    assign tx_push_ok_c = io_wr_tx_c && (!tx_full_c || tx_pop_c);
    assign tx_ovf_set_c = io_wr_tx_c && tx_full_c && !tx_pop_c;

    logic [7:0] status_c;
    logic       tx_idle_c;
    assign tx_idle_c = (tx_count == '0) && (tx_state == TX_IDLE) && !uart_tx_busy;
    assign status_c  = {3'b000, tx_idle_c, tx_ovf, rx_ovf, tx_full_c, rx_count != '0};

    assign rom_addr = address;
    assign irq_rx   = rx_count != '0;

    // Read data mux for the currently presented address
    logic [7:0] rd_mux_c;
    always_comb begin
        rd_mux_c = 8'hFF;
        if (sel_ram_c) begin
            rd_mux_c = ram[ram_idx_c];
        end else if (sel_io_c) begin
            case (address[1:0])
                2'd0:    rd_mux_c = (rx_count != '0) ? rx_mem[rx_rd_ptr] : 8'h00;
                2'd1:    rd_mux_c = status_c;
                default: rd_mux_c = 8'h00;
            endcase
        end else if (sel_vram_c) begin
            rd_mux_c = vram[vram_idx_c];
        end else if (sel_rom_c) begin
            rd_mux_c = rom_data;
        end
    end

    // Bus response: ready one cycle after every accepted request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_ready <= 1'b0;
            rdata     <= 8'h00;
        end else begin
            mem_ready <= mem_read_req || mem_write_req;
            if (rd_c) begin
                rdata <= rd_mux_c;
            end
        end
    end

    // Unreset storage arrays
    always_ff @(posedge clk) begin
        if (wr_c && sel_ram_c) begin
            ram[ram_idx_c] <= wdata;
        end
        if (wr_c && sel_vram_c) begin
            vram[vram_idx_c] <= wdata;
        end
        if (rx_push_ok_c) begin
            rx_mem[rx_wr_ptr] <= uart_rx_data;
        end
        if (tx_push_ok_c) begin
            tx_mem[tx_wr_ptr] <= wdata;
        end
    end

    // VGA port reads VRAM every cycle; same-cycle CPU writes are seen next cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_data <= 8'h00;
        end else begin
            vga_data <= vram[vga_addr];
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else if (flush_c) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push_ok_c) rx_wr_ptr <= rx_wr_ptr + RXQ_AW'(1);
            if (rx_pop_c)     rx_rd_ptr <= rx_rd_ptr + RXQ_AW'(1);
            rx_count <= rx_count + RXC_W'(rx_push_ok_c) - RXC_W'(rx_pop_c);
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (flush_c) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push_ok_c) tx_wr_ptr <= tx_wr_ptr + TXQ_AW'(1);
            if (tx_pop_c)     tx_rd_ptr <= tx_rd_ptr + TXQ_AW'(1);
            tx_count <= tx_count + TXC_W'(tx_push_ok_c) - TXC_W'(tx_pop_c);
        end
    end

    // Sticky overflow flags; a new overflow beats a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ovf <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            rx_ovf <= rx_ovf_set_c || (rx_ovf && !clr_sticky_c);
            tx_ovf <= tx_ovf_set_c || (tx_ovf && !clr_sticky_c);
        end
    end

    // TX FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // TX FSM next state; wait ends on busy fall, or after 4 cycles if busy never rose
    always_comb begin
        tx_next  = tx_state;
        tx_pop_c = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if ((tx_count != '0) && !uart_tx_busy) begin
                    tx_next  = TX_START;
                    tx_pop_c = 1'b1;
                end
            end
            TX_START: tx_next = TX_WAIT;
            TX_WAIT: begin
                if (busy_seen && !uart_tx_busy) begin
                    tx_next = TX_IDLE;
                end else if (!busy_seen && !uart_tx_busy && (wait_cnt == 2'd3)) begin
                    tx_next = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // Busy tracking while waiting on the UART core
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_seen <= 1'b0;
            wait_cnt  <= 2'd0;
        end else if (tx_state == TX_WAIT) begin
            if (uart_tx_busy) busy_seen <= 1'b1;
            if (wait_cnt != 2'd3) wait_cnt <= wait_cnt + 2'd1;
        end else begin
            busy_seen <= 1'b0;
            wait_cnt  <= 2'd0;
        end
    end

    // Registered byte and start pulse towards the UART core
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uart_tx_start <= 1'b0;
            uart_tx_data  <= 8'h00;
        end else begin
            uart_tx_start <= tx_pop_c;
            if (tx_pop_c) begin
                uart_tx_data <= tx_mem[tx_rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_memory_bus_ctrl.sv
// Directed bench for memory_bus_ctrl with a simple UART busy model.
module tb_memory_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        mem_read_req;
    logic        mem_write_req;
    logic        mem_ready;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_start;
    logic        uart_tx_busy = 1'b0;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_ready;
    logic [9:0]  vga_addr;
    logic [7:0]  vga_data;
    logic        irq_rx;

    int vectors     = 0;
    int miscompares = 0;
    int busy_cnt    = 0;
    logic busy_hold = 1'b0;
    logic [7:0] tx_log [$];
    logic [7:0] rd;
    int n0;

    memory_bus_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .wdata         (wdata),
        .rdata         (rdata),
        .mem_read_req  (mem_read_req),
        .mem_write_req (mem_write_req),
        .mem_ready     (mem_ready),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_start (uart_tx_start),
        .uart_tx_busy  (uart_tx_busy),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_ready (uart_rx_ready),
        .vga_addr      (vga_addr),
        .vga_data      (vga_data),
        .irq_rx        (irq_rx)
    );

    always #5 clk = ~clk;

    assign rom_data = rom_addr[7:0] ^ 8'h5A;

    // UART core model: busy for 10 cycles after each start; log started bytes
    always @(negedge clk) begin
        if (uart_tx_start) tx_log.push_back(uart_tx_data);
        if (busy_hold) begin
            uart_tx_busy = 1'b1;
        end else if (uart_tx_start) begin
            busy_cnt     = 10;
            uart_tx_busy = 1'b1;
        end else begin
            if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
            uart_tx_busy = (busy_cnt != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        address       = a;
        wdata         = d;
        mem_write_req = 1'b1;
        @(negedge clk);
        mem_write_req = 1'b0;
        check("wr_ready", 32'(mem_ready), 32'd1);
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        address      = a;
        mem_read_req = 1'b1;
        @(negedge clk);
        mem_read_req = 1'b0;
        check("rd_ready", 32'(mem_ready), 32'd1);
        d = rdata;
    endtask

    initial begin
        reset_n       = 1'b0;
        address       = 16'h0000;
        wdata         = 8'h00;
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        uart_rx_data  = 8'h00;
        uart_rx_ready = 1'b0;
        vga_addr      = 10'd0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_tx_start", 32'(uart_tx_start), 32'd0);
        check("rst_tx_data", 32'(uart_tx_data), 32'h00);
        check("rst_vga", 32'(vga_data), 32'h00);
        check("rst_irq", 32'(irq_rx), 32'd0);
        reset_n = 1'b1;

        // RAM write/read, ready pulse width, unmapped read
        cpu_write(16'h0123, 8'hA5);
        cpu_read(16'h0123, rd);
        check("ram_rd", 32'(rd), 32'hA5);
        @(negedge clk);
        check("ready_pulse", 32'(mem_ready), 32'd0);
        cpu_read(16'h9000, rd);
        check("unmapped_rd", 32'(rd), 32'hFF);

        // Back-to-back write then read to the same RAM byte
        @(negedge clk);
        address = 16'h0200; wdata = 8'h33; mem_write_req = 1'b1;
        @(negedge clk);
        mem_write_req = 1'b0; mem_read_req = 1'b1;
        check("b2b_ready0", 32'(mem_ready), 32'd1);
        @(negedge clk);
        mem_read_req = 1'b0;
        check("b2b_ready1", 32'(mem_ready), 32'd1);
        check("b2b_rdata", 32'(rdata), 32'h33);

        // VRAM vs VGA port, ROM region
        cpu_write(16'hE005, 8'h41);
        vga_addr = 10'd5;
        @(negedge clk);
        check("vga_data", 32'(vga_data), 32'h41);
        cpu_read(16'hE005, rd);
        check("vram_rd", 32'(rd), 32'h41);
        cpu_read(16'hC003, rd);
        check("rom_rd", 32'(rd), 32'h59);
        cpu_read(16'hD012, rd);
        check("txdata_rd", 32'(rd), 32'h00);

        // Three TX bytes drained through the busy model
        cpu_write(16'hD012, 8'h10);
        cpu_write(16'hD012, 8'h11);
        cpu_write(16'hD012, 8'h12);
        repeat (60) @(negedge clk);
        check("tx_cnt3", 32'(tx_log.size()), 32'd3);
        if (tx_log.size() >= 3) begin
            check("tx_b0", 32'(tx_log[0]), 32'h10);
            check("tx_b1", 32'(tx_log[1]), 32'h11);
            check("tx_b2", 32'(tx_log[2]), 32'h12);
        end
        cpu_read(16'hD011, rd);
        check("status_idle", 32'(rd), 32'h10);

        // TX overflow with busy held high, sticky clear, flush
        busy_hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 17; i++) cpu_write(16'hD012, 8'(8'h20 + i));
        cpu_read(16'hD011, rd);
        check("status_txfull", 32'(rd), 32'h0A);
        cpu_write(16'hD013, 8'h01);
        cpu_read(16'hD011, rd);
        check("status_txclr", 32'(rd), 32'h02);
        cpu_write(16'hD013, 8'h02);
        cpu_read(16'hD011, rd);
        check("status_flush", 32'(rd), 32'h00);
        busy_hold = 1'b0;
        repeat (20) @(negedge clk);
        check("tx_none_after_flush", 32'(tx_log.size()), 32'd3);
        cpu_read(16'hD011, rd);
        check("status_idle2", 32'(rd), 32'h10);

        // RX overflow and drain
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            uart_rx_ready = 1'b1;
            uart_rx_data  = 8'(i);
            @(negedge clk);
            uart_rx_ready = 1'b0;
        end
        check("irq_full", 32'(irq_rx), 32'd1);
        cpu_read(16'hD011, rd);
        check("status_rxovf", 32'(rd), 32'h15);
        for (int i = 0; i < 16; i++) begin
            cpu_read(16'hD010, rd);
            check("rx_byte", 32'(rd), 32'(i));
            if (i == 14) check("irq_before_last", 32'(irq_rx), 32'd1);
        end
        check("irq_empty", 32'(irq_rx), 32'd0);
        cpu_read(16'hD010, rd);
        check("rx_empty_rd", 32'(rd), 32'h00);
        cpu_read(16'hD011, rd);
        check("status_rxsticky", 32'(rd), 32'h14);
        cpu_write(16'hD013, 8'h01);

        // Reset in the middle of TX_WAIT with bytes still queued
        n0 = tx_log.size();
        cpu_write(16'hD012, 8'h50);
        cpu_write(16'hD012, 8'h51);
        cpu_write(16'hD012, 8'h52);
        for (int i = 0; i < 50 && tx_log.size() < n0 + 1; i++) @(negedge clk);
        check("tx_first_started", 32'(tx_log.size()), 32'(n0 + 1));
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rdata", 32'(rdata), 32'h00);
        check("mid_rst_ready", 32'(mem_ready), 32'd0);
        check("mid_rst_start", 32'(uart_tx_start), 32'd0);
        check("mid_rst_txdata", 32'(uart_tx_data), 32'h00);
        check("mid_rst_vga", 32'(vga_data), 32'h00);
        check("mid_rst_irq", 32'(irq_rx), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("no_tx_after_rst", 32'(tx_log.size()), 32'(n0 + 1));
        cpu_read(16'hD011, rd);
        check("status_after_rst", 32'(rd), 32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
